// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if #(
   parameter int BIT_WIDTH = 32
);
   logic                 imem_req;
   logic [BIT_WIDTH-1:0] imem_addr;
   logic                 imem_rvalid;
   logic [BIT_WIDTH-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Multi-cycle MIPS-style fetch unit: FETCH -> WAIT -> EXEC, holding the PC,
// instruction register and retired-instruction counter.
module fetch_unit #(
   parameter int                   BIT_WIDTH = 32,
   parameter int                   BIT_CTRL  = 6,
   parameter logic [BIT_WIDTH-1:0] RESET_PC  = 32'h0040_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   fetch_unit_if.master         imem,
   input  logic                 PCWrite,
   input  logic                 Branch,
   input  logic                 jump,
   input  logic                 jregister,
   input  logic                 branch_cond,
   input  logic [BIT_WIDTH-1:0] rs_data,
   output logic [BIT_WIDTH-1:0] instr,
   output logic [BIT_CTRL-1:0]  Op,
   output logic [BIT_CTRL-1:0]  Funct,
   output logic                 instr_valid,
   output logic [BIT_WIDTH-1:0] pc,
   output logic [BIT_WIDTH-1:0] pc_plus4,
   output logic                 addr_err,
   output logic [BIT_WIDTH-1:0] retired_cnt
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      EXEC  = 2'd2
   } state_t;

   localparam logic [BIT_WIDTH-1:0] FOUR = BIT_WIDTH'(4);
   localparam logic [BIT_WIDTH-1:0] ONE  = BIT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [BIT_WIDTH-1:0] pc_q, pc_d;
   logic [BIT_WIDTH-1:0] instr_q, instr_d;
   logic [BIT_WIDTH-1:0] retired_q, retired_d;
   logic                 pend_q, pend_d;

   logic [BIT_WIDTH-1:0] pc_plus4_w;
   logic [BIT_WIDTH-1:0] br_tgt;
   logic [BIT_WIDTH-1:0] next_pc;
   logic                 imem_req_c;
   logic                 instr_valid_c;
   logic                 addr_err_c;

   // Word offset of a conditional branch: sign-extended imm16 scaled by 4.
   function automatic logic signed [BIT_WIDTH-1:0] branch_off(input logic [15:0] imm);
      logic signed [BIT_WIDTH-1:0] ext;
      ext = {{(BIT_WIDTH-18){imm[15]}}, imm, 2'b00};
      return ext;
   endfunction

   assign pc_plus4_w = pc_q + FOUR;
   assign br_tgt     = pc_plus4_w + $unsigned(branch_off(instr_q[15:0]));

   always_comb begin
      next_pc = pc_plus4_w;
      if (jregister)
         next_pc = {rs_data[BIT_WIDTH-1:2], 2'b00};
      else if (jump)
         next_pc = {pc_plus4_w[BIT_WIDTH-1:28], instr_q[25:0], 2'b00};
      else if (Branch && branch_cond)
         next_pc = br_tgt;
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      retired_d     = retired_q;
      pend_d        = pend_q;
      imem_req_c    = 1'b0;
      instr_valid_c = 1'b0;
      addr_err_c    = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req_c = 1'b1;
            pend_d     = 1'b1;
            state_d    = WAIT;
         end
         WAIT: begin
            if (imem.imem_rvalid && pend_q) begin
               instr_d = imem.imem_rdata;
               pend_d  = 1'b0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            instr_valid_c = 1'b1;
            // Without PCWrite the control unit is stalling: hold everything.
            if (PCWrite) begin
               pc_d       = next_pc;
               retired_d  = retired_q + ONE;
               state_d    = FETCH;
               addr_err_c = jregister && (rs_data[1:0] != 2'b00);
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         retired_q <= '0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         pend_q    <= pend_d;
      end
   end

   // Request is masked while reset is held so the bus is quiet during reset.
   assign imem.imem_req  = imem_req_c && rst;
   assign imem.imem_addr = pc_q;

   assign instr       = instr_q;
   assign Op          = instr_q[31 -: BIT_CTRL];
   assign Funct       = instr_q[BIT_CTRL-1:0];
   assign instr_valid = instr_valid_c;
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_w;
   assign addr_err    = addr_err_c;
   assign retired_cnt = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: instruction-chain vector table driven through a
// memory responder with an instruction scoreboard, plus stall/reset sequences.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk;
   logic        rst;
   logic        PCWrite, Branch, jump, jregister, branch_cond;
   logic [31:0] rs_data;
   logic [31:0] instr, pc, pc_plus4, retired_cnt;
   logic [5:0]  Op, Funct;
   logic        instr_valid, addr_err;

   fetch_unit_if #(.BIT_WIDTH(32)) imem_bus ();

   fetch_unit #(
      .BIT_WIDTH(32),
      .BIT_CTRL (6),
      .RESET_PC (RST_PC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem       (imem_bus),
      .PCWrite    (PCWrite),
      .Branch     (Branch),
      .jump       (jump),
      .jregister  (jregister),
      .branch_cond(branch_cond),
      .rs_data    (rs_data),
      .instr      (instr),
      .Op         (Op),
      .Funct      (Funct),
      .instr_valid(instr_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .addr_err   (addr_err),
      .retired_cnt(retired_cnt)
   );

   typedef struct {
      logic [31:0] word;
      logic        br;
      logic        bc;
      logic        jmp;
      logic        jr;
      logic [31:0] rs;
      logic [31:0] pc_exp;
      logic [31:0] npc_exp;
      logic        aerr;
      int          lat;
   } vec_t;

   vec_t        vecs [11];
   int          n_tests;
   int          n_fail;
   logic [31:0] sb_q [$];
   logic [31:0] exp_ret;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_ctrl();
      PCWrite = 1'b0; Branch = 1'b0; jump = 1'b0; jregister = 1'b0;
      branch_cond = 1'b0; rs_data = '0;
   endtask

   task automatic wait_req(input logic [31:0] exp_addr);
      int k;
      k = 0;
      while (!imem_bus.imem_req && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("imem_req_seen", {31'b0, imem_bus.imem_req}, 32'd1);
      chk("imem_addr", imem_bus.imem_addr, exp_addr);
   endtask

   // Memory responder: answers lat cycles after the request cycle.
   task automatic respond(input logic [31:0] w, input int lat);
      for (int j = 0; j < lat; j++) begin
         @(negedge clk);
         if (j == 0) begin
            chk("req_drop_in_wait", {31'b0, imem_bus.imem_req}, 32'd0);
            chk("valid_low_in_wait", {31'b0, instr_valid}, 32'd0);
         end
      end
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = w;
      sb_q.push_back(w);
      @(negedge clk);
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
   endtask

   task automatic wait_exec();
      int          k;
      logic [31:0] e;
      k = 0;
      while (!instr_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("instr_valid_exec", {31'b0, instr_valid}, 32'd1);
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_empty: got instr %h expected none pending", instr);
      end else begin
         e = sb_q.pop_front();
         chk("instr", instr, e);
      end
   endtask

   task automatic retire(input logic [31:0] exp_npc, input logic exp_aerr);
      PCWrite = 1'b1;
      #1;
      chk("addr_err", {31'b0, addr_err}, {31'b0, exp_aerr});
      @(negedge clk);
      clear_ctrl();
      exp_ret = exp_ret + 32'd1;
      chk("next_pc", pc, exp_npc);
      chk("retired_cnt", retired_cnt, exp_ret);
      chk("valid_low_fetch", {31'b0, instr_valid}, 32'd0);
   endtask

   initial begin
      vec_t        v;
      logic [31:0] w;
      n_tests = 0;
      n_fail  = 0;
      exp_ret = '0;
      //                word          br    bc    jmp   jr    rs              pc_exp          npc_exp         aerr  lat
      vecs[0]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0040_0000, 32'h0040_0004, 1'b0, 2};
      vecs[1]  = '{32'h0810_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          32'h0040_0004, 32'h0040_0010, 1'b0, 1};
      vecs[2]  = '{32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          32'h0040_0010, 32'h0040_0010, 1'b0, 3};
      vecs[3]  = '{32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0040_0010, 32'h0040_0014, 1'b0, 1};
      vecs[4]  = '{32'h0810_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          32'h0040_0014, 32'h0040_0020, 1'b0, 2};
      vecs[5]  = '{32'h0C10_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          32'h0040_0020, 32'h0040_0020, 1'b0, 1};
      vecs[6]  = '{32'h03E0_0008, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0033, 32'h0040_0020, 32'h0040_0030, 1'b1, 4};
      vecs[7]  = '{32'h1400_0003, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          32'h0040_0030, 32'h0040_0040, 1'b0, 1};
      vecs[8]  = '{32'h03E0_0008, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0040_0040, 32'hFFFF_FFFC, 1'b0, 2};
      vecs[9]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1};
      vecs[10] = '{32'h0810_0000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          32'h0000_0000, 32'h0040_0000, 1'b0, 2};

      rst = 1'b0;
      clear_ctrl();
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
      repeat (3) @(negedge clk);
      chk("rst_pc", pc, RST_PC);
      chk("rst_instr", instr, 32'h0);
      chk("rst_retired", retired_cnt, 32'h0);
      chk("rst_imem_req", {31'b0, imem_bus.imem_req}, 32'd0);
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
      rst = 1'b1;
      #1;
      chk("first_req_after_rst", {31'b0, imem_bus.imem_req}, 32'd1);

      for (int i = 0; i < 11; i++) begin
         v = vecs[i];
         w = v.word;
         wait_req(v.pc_exp);
         respond(v.word, v.lat);
         wait_exec();
         chk("exec_pc", pc, v.pc_exp);
         chk("Op", {26'b0, Op}, {26'b0, w[31:26]});
         chk("Funct", {26'b0, Funct}, {26'b0, w[5:0]});
         chk("pc_plus4", pc_plus4, v.pc_exp + 32'd4);
         Branch = v.br; branch_cond = v.bc; jump = v.jmp; jregister = v.jr; rs_data = v.rs;
         #1;
         chk("aerr_no_pcwrite", {31'b0, addr_err}, 32'd0);
         retire(v.npc_exp, v.aerr);
      end

      // Stall for five cycles with a stray response arriving mid-stall.
      wait_req(RST_PC);
      respond(32'h2008_0005, 3);
      wait_exec();
      for (int c = 0; c < 5; c++) begin
         imem_bus.imem_rvalid = (c == 1);
         imem_bus.imem_rdata  = 32'hDEAD_BEEF;
         @(negedge clk);
         chk("stall_pc", pc, RST_PC);
         chk("stall_instr", instr, 32'h2008_0005);
         chk("stall_retired", retired_cnt, exp_ret);
         chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      end
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
      retire(32'h0040_0004, 1'b0);

      // Reset while a fetch is outstanding; late response lands in FETCH.
      wait_req(32'h0040_0004);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_pc", pc, RST_PC);
      chk("async_rst_retired", retired_cnt, 32'h0);
      chk("async_rst_instr", instr, 32'h0);
      chk("async_rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
      chk("async_rst_valid", {31'b0, instr_valid}, 32'd0);
      exp_ret = '0;
      @(negedge clk);
      rst = 1'b1;
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = 32'hBADC_0DE0;
      #1;
      chk("refetch_req", {31'b0, imem_bus.imem_req}, 32'd1);
      chk("refetch_addr", imem_bus.imem_addr, RST_PC);
      @(negedge clk);
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
      chk("late_rvalid_ignored", instr, 32'h0);
      chk("late_rvalid_valid", {31'b0, instr_valid}, 32'd0);
      @(negedge clk);
      chk("wait_holds", {31'b0, instr_valid}, 32'd0);
      respond(32'h2008_0005, 0);
      wait_exec();
      chk("post_rst_Op", {26'b0, Op}, 32'd8);
      retire(32'h0040_0004, 1'b0);

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
